// File: rtl/rv32i_pkg.sv
// Shared constants for the RV32I stage sequencer: opcodes, state encoding,
// error codes and the default handshake wait limit.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_ALU_TO  = 2'b10;
  localparam logic [1:0] ERR_MEM_TO  = 2'b11;

  localparam int WAIT_LIMIT_DEF = 16;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_OP: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Handshake wait counter: clears on request, counts while enabled and flags
// the cycle in which the LIMIT-th consecutive wait cycle is being spent.
module wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (en && !expired) cnt <= cnt + CW'(1);
  end

  // count 0 is the first cycle in the state, so LIMIT-1 marks the last allowed one
  assign expired = (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK controller for the RV32I core.
// Define PERF_CTR_EN to build the cycle and retired-instruction counters.
module stage_sequencer
  import rv32i_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic             alu_valid,
  input  logic             mem_ready,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_update,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [WIDTH-1:0] cycle_cnt,
  output logic [WIDTH-1:0] instret_cnt
);

  state_t     state_q, state_n;
  logic [6:0] op_q;
  logic [1:0] err_q, err_n;
  logic       expired, timer_clr, timer_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
      op_q    <= '0;
    end else begin
      state_q <= state_n;
      err_q   <= err_n;
      if (state_q == S_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    state_n   = state_q;
    err_n     = err_q;
    pc_update = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_n = S_FETCH;
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        if (is_legal(opcode)) begin
          state_n = S_EXECUTE;
        end else begin
          state_n = S_HALT;
          err_n   = (opcode == OP_SYSTEM) ? ERR_NONE : ERR_ILLEGAL;
        end
      end
      S_EXECUTE: begin
        if (alu_valid) begin
          if (op_q == OP_LOAD || op_q == OP_STORE) begin
            state_n = S_MEMORY;
          end else if (op_q == OP_BRANCH) begin
            state_n   = S_FETCH;
            pc_update = 1'b1;
          end else begin
            state_n = S_WRITEBACK;
          end
        end else if (expired) begin
          state_n = S_HALT;
          err_n   = ERR_ALU_TO;
        end
      end
      S_MEMORY: begin
        if (mem_ready) begin
          if (op_q == OP_LOAD) begin
            state_n = S_WRITEBACK;
          end else begin
            state_n   = S_FETCH;
            pc_update = 1'b1;
          end
        end else if (expired) begin
          state_n = S_HALT;
          err_n   = ERR_MEM_TO;
        end
      end
      S_WRITEBACK: begin
        state_n   = S_FETCH;
        pc_update = 1'b1;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
  end

  // any state change restarts the wait window for the next handshake
  assign timer_clr = (state_n != state_q);
  assign timer_en  = (state_q == S_EXECUTE && !alu_valid) ||
                     (state_q == S_MEMORY  && !mem_ready);

  wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  assign if_en    = (state_q == S_FETCH);
  assign id_en    = (state_q == S_DECODE);
  assign ex_en    = (state_q == S_EXECUTE);
  assign mem_en   = (state_q == S_MEMORY);
  assign wb_en    = (state_q == S_WRITEBACK);
  assign halted   = (state_q == S_HALT);
  assign state    = state_q;
  assign err_code = err_q;

`ifdef PERF_CTR_EN
  logic [WIDTH-1:0] cyc_q, ret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT) cyc_q <= cyc_q + WIDTH'(1);
      if (pc_update) ret_q <= ret_q + WIDTH'(1);
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: per-instruction timing model expands each program
// into an expected cycle trace, which drives the inputs and is checked cycle by cycle.
module tb_stage_sequencer;

  localparam int LIM = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  opcode = '0;
  logic        alu_valid = 1'b0;
  logic        mem_ready = 1'b0;
  logic        if_en, id_en, ex_en, mem_en, wb_en, pc_update, halted;
  logic [2:0]  state;
  logic [1:0]  err_code;
  logic [31:0] cycle_cnt, instret_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc_m = 0;
  int ret_m = 0;

  typedef struct {
    int         st;
    bit         pcu;
    int         err;
    logic [6:0] op;
    bit         av;
    bit         mr;
    bit         go;
  } ent_t;

  ent_t q[$];

  stage_sequencer #(.WIDTH(32), .WAIT_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .alu_valid(alu_valid), .mem_ready(mem_ready),
    .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
    .pc_update(pc_update), .state(state), .halted(halted), .err_code(err_code),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [6:0] op);
    return op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111 ||
           op == 7'b1100111 || op == 7'b1100011 || op == 7'b0000011 ||
           op == 7'b0100011 || op == 7'b0010011 || op == 7'b0110011;
  endfunction

  // a cycle with random "don't care" inputs
  function automatic ent_t mk(input int st, input bit pcu, input int err);
    ent_t e;
    e.st = st; e.pcu = pcu; e.err = err;
    e.op = 7'($urandom); e.av = 1'($urandom); e.mr = 1'($urandom); e.go = 1'($urandom);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input ent_t e);
    logic [4:0] en_exp;
    en_exp = {e.st == 1, e.st == 2, e.st == 3, e.st == 4, e.st == 5};
    check("state", 32'(state), 32'(e.st));
    check("enables", 32'({if_en, id_en, ex_en, mem_en, wb_en}), 32'(en_exp));
    check("pc_update", 32'(pc_update), 32'(e.pcu));
    check("halted", 32'(halted), 32'(e.st == 6));
    check("err_code", 32'(err_code), 32'(e.err));
`ifdef PERF_CTR_EN
    check("cycle_cnt", cycle_cnt, 32'(cyc_m));
    check("instret_cnt", instret_cnt, 32'(ret_m));
`else
    check("cycle_cnt", cycle_cnt, 32'd0);
    check("instret_cnt", instret_cnt, 32'd0);
`endif
  endtask

  // expands a program into its expected per-cycle trace
  task automatic build(input int n, input logic [6:0] ops[4], input int aws[4], input int mws[4]);
    ent_t e;
    bit   halt = 0;
    int   herr = 0;
    q.delete();
    repeat ($urandom_range(0, 2)) begin e = mk(0, 0, 0); e.go = 0; q.push_back(e); end
    e = mk(0, 0, 0); e.go = 1; q.push_back(e);
    for (int i = 0; i < n && !halt; i++) begin
      q.push_back(mk(1, 0, 0));
      e = mk(2, 0, 0); e.op = ops[i]; q.push_back(e);
      if (!legal(ops[i])) begin
        halt = 1; herr = (ops[i] == 7'b1110011) ? 0 : 1;
        break;
      end
      for (int k = 0; ; k++) begin
        e = mk(3, 0, 0);
        if (k == aws[i]) begin
          e.av = 1; e.pcu = (ops[i] == 7'b1100011); q.push_back(e); break;
        end
        e.av = 0; q.push_back(e);
        if (k == LIM - 1) begin halt = 1; herr = 2; break; end
      end
      if (halt) break;
      if (ops[i] == 7'b0000011 || ops[i] == 7'b0100011) begin
        for (int k = 0; ; k++) begin
          e = mk(4, 0, 0);
          if (k == mws[i]) begin
            e.mr = 1; e.pcu = (ops[i] == 7'b0100011); q.push_back(e); break;
          end
          e.mr = 0; q.push_back(e);
          if (k == LIM - 1) begin halt = 1; herr = 3; break; end
        end
        if (halt) break;
      end
      if (ops[i] != 7'b1100011 && ops[i] != 7'b0100011) q.push_back(mk(5, 1, 0));
    end
    if (halt) begin
      repeat (3) begin e = mk(6, 0, herr); e.go = 1; q.push_back(e); end
    end else begin
      q.push_back(mk(1, 0, 0));
    end
  endtask

  task automatic check_reset_state();
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", 32'({if_en, id_en, ex_en, mem_en, wb_en, pc_update, halted, err_code}), 32'd0);
    check("rst_counters", cycle_cnt | instret_cnt, 32'd0);
  endtask

  // cut_mode: 0 whole trace, 1 stop in the second MEMORY cycle, 2 random cut
  task automatic trial(input int n, input logic [6:0] ops[4], input int aws[4],
                       input int mws[4], input int cut_mode);
    int len;
    build(n, ops, aws, mws);
    len = q.size();
    if (cut_mode == 1) begin
      for (int i = 0; i < q.size(); i++)
        if (q[i].st == 4) begin len = i + 2; break; end
    end else if (cut_mode == 2) begin
      len = $urandom_range(1, q.size());
    end
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      opcode = q[i].op; alu_valid = q[i].av; mem_ready = q[i].mr; start = q[i].go;
      #1;
      check_cycle(q[i]);
      if (q[i].st != 0 && q[i].st != 6) cyc_m++;
      if (q[i].pcu) ret_m++;
    end
    #2 rst = 1'b1;
    #1 check_reset_state();
    cyc_m = 0; ret_m = 0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
  endtask

  logic [6:0] ops[4];
  int         aws[4];
  int         mws[4];
  logic [6:0] legal_ops[9];

  initial begin
    legal_ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                  7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    repeat (2) @(negedge clk);
    #1 check_reset_state();
    @(negedge clk);
    rst = 1'b0;

    ops = '{7'b0110011, 7'b0, 7'b0, 7'b0}; aws = '{0, 0, 0, 0}; mws = '{0, 0, 0, 0};
    trial(1, ops, aws, mws, 0);
    ops = '{7'b0000011, 7'b0, 7'b0, 7'b0}; aws = '{2, 0, 0, 0}; mws = '{3, 0, 0, 0};
    trial(1, ops, aws, mws, 0);
    ops = '{7'b0100011, 7'b1100011, 7'b0010011, 7'b1101111}; aws = '{1, 0, 3, 0}; mws = '{0, 0, 0, 0};
    trial(4, ops, aws, mws, 0);
    ops = '{7'b0000000, 7'b0, 7'b0, 7'b0};
    trial(1, ops, aws, mws, 0);
    ops = '{7'b1110011, 7'b0, 7'b0, 7'b0};
    trial(1, ops, aws, mws, 0);
    ops = '{7'b0110011, 7'b0, 7'b0, 7'b0}; aws = '{100, 0, 0, 0};
    trial(1, ops, aws, mws, 0);
    ops = '{7'b0110011, 7'b0000011, 7'b0, 7'b0}; aws = '{15, 0, 0, 0}; mws = '{0, 15, 0, 0};
    trial(2, ops, aws, mws, 0);
    ops = '{7'b0000011, 7'b0, 7'b0, 7'b0}; aws = '{0, 0, 0, 0}; mws = '{100, 0, 0, 0};
    trial(1, ops, aws, mws, 0);
    ops = '{7'b0000011, 7'b0, 7'b0, 7'b0}; aws = '{1, 0, 0, 0}; mws = '{5, 0, 0, 0};
    trial(1, ops, aws, mws, 1);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r == 0)      ops[i] = 7'b1110011;
        else if (r == 1) ops[i] = 7'($urandom);
        else             ops[i] = legal_ops[$urandom_range(0, 8)];
        aws[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
        mws[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
      end
      trial($urandom_range(1, 4), ops, aws, mws, ($urandom_range(0, 1) == 0) ? 0 : 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Multi-cycle stage controller for the RV32I core. It steps one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. Stages are skipped according to the latched opcode. Per-stage enables and the PC update strobe feed the control unit, register file, ALU, data memory and program counter. Handshakes on ALU completion and memory ready are bounded by a wait timeout; illegal or SYSTEM opcodes halt the core.

Parameters:
WIDTH, 32, datapath/counter width
WAIT_LIMIT, 16, max cycles spent waiting in EXECUTE or MEMORY before error halt (1..255)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous reset, active-high
start  input  1  begin execution from IDLE (level sampled, ignored elsewhere)
opcode  input  7  inst_data[6:0] from instruction memory, sampled in DECODE
alu_valid  input  1  ALU result ready
mem_ready  input  1  data memory access complete
if_en  output  1  fetch stage enable
id_en  output  1  decode stage enable
ex_en  output  1  execute stage enable (drives alu_en)
mem_en  output  1  memory stage enable (gates DM_read/DM_write)
wb_en  output  1  writeback enable (gates reg_write_en)
pc_update  output  1  one-cycle strobe: PC may advance (inverse of PC_stall)
state  output  3  current state encoding (debug)
halted  output  1  sequencer in HALT
err_code  output  2  00 none, 01 illegal opcode, 10 ALU timeout, 11 memory timeout
cycle_cnt  output  WIDTH  cycle counter (see optional feature)
instret_cnt  output  WIDTH  retired instruction counter (see optional feature)

Behaviour:
- Reset: async, active-high; state=IDLE; every output 0; opcode latch, wait counter, err_code cleared. Reset mid-instruction abandons it; no pc_update is issued.
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6.
- Stage enables are Moore decodes of the state register. Exactly one is high in states 1..5; none in IDLE/HALT.
- IDLE -> FETCH when start=1.
- FETCH -> DECODE unconditionally, 1 cycle.
- DECODE: latch opcode into op_q. Legal set: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - Legal opcode -> EXECUTE.
  - SYSTEM 1110011 -> HALT, err_code=00.
  - Any other opcode -> HALT, err_code=01.
- EXECUTE: stays while alu_valid=0, wait counter incrementing. When alu_valid=1:
  - LOAD/STORE -> MEMORY.
  - BRANCH -> FETCH, with pc_update=1 in this same cycle.
  - All other opcodes -> WRITEBACK.
  - If the counter reaches WAIT_LIMIT with alu_valid=0 -> HALT, err_code=10. alu_valid=1 on the limit cycle wins.
- MEMORY: same wait rule on mem_ready. When mem_ready=1:
  - LOAD -> WRITEBACK.
  - STORE -> FETCH with pc_update=1.
  - Timeout -> HALT, err_code=11.
- WRITEBACK: 1 cycle, pc_update=1, -> FETCH.
- Wait counter clears on every state entry.
- pc_update is combinational from state plus the handshake input, and is high only in the final cycle of an instruction.
- Minimum CPI: 4 for ALU/jump (F,D,E,W), 3 for branch, 4 for store, 5 for load.
- HALT is sticky until rst. start, alu_valid and mem_ready are ignored there.
- alu_valid or mem_ready asserted outside their states are ignored.

Optional Feature:
PERF_CTR_EN defined:
- cycle_cnt increments every cycle the state is not IDLE or HALT.
- instret_cnt increments on each pc_update.
- Both wrap modulo 2^WIDTH and clear on rst.

PERF_CTR_EN undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Package rv32i_pkg holds:
  - opcode constants
  - state encoding constants
  - err_code constants
  - WAIT_LIMIT default
- One natural sub-module, wait_timer: clear/enable/expired counter, width $clog2(WAIT_LIMIT+1), instanced once and shared by EXECUTE and MEMORY.

Test Plan:
- OP instr 0110011, start at cycle 0, alu_valid=1 on first EXECUTE cycle -> if_en@1, id_en@2, ex_en@3, wb_en+pc_update@4, if_en@5; instret_cnt=1 with PERF_CTR_EN.
- LOAD 0000011, alu_valid after 2 wait cycles, mem_ready after 3 -> sequence F,D,E,E,E,M,M,M,M,W; single pc_update in W.
- STORE and BRANCH -> wb_en never asserts; pc_update in last MEMORY cycle (store) / EXECUTE cycle (branch); next cycle FETCH.
- opcode 0000000 -> HALT after DECODE, halted=1, err_code=01; later start pulses are ignored.
- OP with alu_valid held 0, WAIT_LIMIT=16 -> HALT with err_code=10 after 16 EXECUTE cycles; pc_update never asserts.
- rst asserted during MEMORY -> state=0 and all outputs 0 immediately (asynchronous); counters 0; start then restarts cleanly at FETCH.
